nfca_rx_bitparse: RTL
=====================

NFCA_RX_BITPARSE -- requirements
Module: nfca_rx_bitparse

Interface
REQ-001 Parameter HALF_SAMPLES, default 12, samples per half-bit at rate code 0; SHALL be a multiple of 4, range 8..32.
REQ-002 Parameter ONE_TH, default 3, minimum window sum classified as subcarrier-present ("one").
REQ-003 Parameter ZERO_TH, default 1, maximum window sum classified as subcarrier-absent ("zero"); ZERO_TH < ONE_TH.
REQ-004 Parameter IDLE_GAP, default 48, consecutive all-zero samples in STOP before re-arming to IDLE.
REQ-005 Parameter MAX_BITS, default 4096, frame bit limit; used only with the macro in REQ-027.
REQ-006 clk  input  1  core clock, 81.36 MHz.
REQ-007 rstn  input  1  reset, synchronous, active-low.
REQ-008 rate  input  2  0=106k, 1=212k, 2=424k, 3=reserved; sampled only in IDLE.
REQ-009 rx_ask_en  input  1  sample strobe; at most one per clk.
REQ-010 rx_ask  input  1  demodulated subcarrier sample, valid when rx_ask_en=1.
REQ-011 rx_bit_en  output  1  one-cycle pulse, decoded bit valid on rx_bit.
REQ-012 rx_bit  output  1  decoded data bit; S and E excluded.
REQ-013 rx_end  output  1  one-cycle pulse, frame ended (E, collision, error).
REQ-014 rx_end_col  output  1  collision flag, valid only with rx_end.
REQ-015 rx_end_err  output  1  error flag, valid only with rx_end.
REQ-016 rx_bit_cnt  output  13  bits decoded in current/last frame; holds after rx_end until next SOF.

Function
REQ-017 Effective half-bit H = HALF_SAMPLES >> rate; latched on IDLE->PARSE; rate=3 SHALL be treated as 0.
REQ-018 Sample history: 4*HALF_SAMPLES-bit shift register, shifted only on rx_ask_en; four windows of H samples each, W0 newest.
REQ-019 Per window, on each rx_ask_en: one[i] = sum(Wi) >= ONE_TH, zero[i] = sum(Wi) <= ZERO_TH, both registered; classifications SHALL use the shift contents before the shift in the same strobe.
REQ-020 States: IDLE, PARSE, STOP; all transitions and outputs advance only on rx_ask_en cycles.
REQ-021 IDLE: bit counter cleared; when one=4'b0010 and zero=4'b1101, go to PARSE, clear rx_bit_cnt and phase counter.
REQ-022 PARSE: phase counter counts 0..2H-1; at 2H-1 wraps to 0 and decides, in priority order: any window with one==zero -> rx_end+rx_end_err, STOP; one[1:0]=00 -> rx_end, STOP; 11 -> rx_end+rx_end_col, STOP; 10 -> rx_bit_en, rx_bit=1; 01 -> rx_bit_en, rx_bit=0.
REQ-023 Each rx_bit_en increments rx_bit_cnt; saturates at 8191.
REQ-024 STOP: counts consecutive strobes with rx_ask=0, any 1 clears count; at IDLE_GAP go to IDLE; no outputs asserted in STOP.
REQ-025 Pulse outputs assert in the clk after the deciding strobe, for exactly one clk; rx_bit_en and rx_end SHALL never assert together.
REQ-026 rate changes outside IDLE SHALL have no effect on the current frame.

Configuration
REQ-027 Macro NFCA_RX_FRAME_LIMIT_EN defined: when rx_bit_cnt reaches MAX_BITS, the next decision point SHALL issue rx_end+rx_end_err instead of a bit and enter STOP. Undefined: no limit; MAX_BITS unused.

Reset
REQ-028 rstn=0 at a clk edge: state=IDLE, shift register, one/zero flags, phase, gap counter and rx_bit_cnt cleared; all outputs 0 next cycle, including mid-frame.
REQ-029 rx_ask_en during reset SHALL be ignored.

Verification
REQ-030 Defaults, rate=0, SOF then Manchester bits 1,0,1,1 then E (no subcarrier 24 samples) -> four rx_bit_en pulses with rx_bit 1,0,1,1, then rx_end=1, col=0, err=0, rx_bit_cnt=4.
REQ-031 rate=2 (H=3), SOF, bits 0,1 -> two rx_bit_en, rx_bit 0,1; decisions every 6 strobes.
REQ-032 Subcarrier in both halves of bit 3 -> after two bits, rx_end=1 with rx_end_col=1, rx_bit_cnt=2.
REQ-033 Window sum=2 in a decision window -> rx_end=1, rx_end_err=1; STOP then IDLE after 48 zero strobes; new SOF accepted.
REQ-034 rstn=0 mid-frame after 5 bits -> no further pulses, rx_bit_cnt=0; next SOF decodes normally.
REQ-035 With NFCA_RX_FRAME_LIMIT_EN, MAX_BITS=8, 10-bit frame -> 8 bits, then rx_end+rx_end_err; without macro -> 10 bits, clean rx_end.

Source files
------------

// File: rtl/nfca_rx_bitparse_if.sv
`default_nettype none
// ============================================================================
//  Module      : nfca_rx_bitparse_if
//  Description : Sample-in / decoded-bit-out bundle for the NFC-A receive
//                Manchester bit parser.
//  Revision    : 1.0  initial release
// ============================================================================
interface nfca_rx_bitparse_if;
    logic [1:0]  rate;
    logic        rx_ask_en;
    logic        rx_ask;
    logic        rx_bit_en;
    logic        rx_bit;
    logic        rx_end;
    logic        rx_end_col;
    logic        rx_end_err;
    logic [12:0] rx_bit_cnt;

    // Sample source / decoded-bit consumer side
    modport master (
        output rate, rx_ask_en, rx_ask,
        input  rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err, rx_bit_cnt
    );

    // Parser side
    modport slave (
        input  rate, rx_ask_en, rx_ask,
        output rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err, rx_bit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/nfca_rx_bitparse.sv
`default_nettype none
// ============================================================================
//  Module      : nfca_rx_bitparse
//  Description : NFC-A (ISO 14443-A) PICC->PCD Manchester bit parser. Keeps a
//                four-half-bit sample history, classifies each half-bit window
//                as subcarrier present/absent, detects SOF and emits data bits
//                until end of frame, collision or error.
//                Optional build macro NFCA_RX_FRAME_LIMIT_EN ends a frame with
//                an error once MAX_BITS bits have been decoded.
//  Revision    : 1.0  initial release
// ============================================================================
module nfca_rx_bitparse #(
    parameter int HALF_SAMPLES = 12,
    parameter int ONE_TH       = 3,
    parameter int ZERO_TH      = 1,
    parameter int IDLE_GAP     = 48,
    parameter int MAX_BITS     = 4096
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    nfca_rx_bitparse_if.slave    bus
);

    localparam int c_sr_w  = 4 * HALF_SAMPLES;
    localparam int c_sum_w = $clog2(HALF_SAMPLES + 1);
    localparam int c_ph_w  = $clog2(2 * HALF_SAMPLES);
    localparam int c_gap_w = $clog2(IDLE_GAP + 1);

    localparam logic [c_sum_w-1:0] c_one_th   = c_sum_w'(ONE_TH);
    localparam logic [c_sum_w-1:0] c_zero_th  = c_sum_w'(ZERO_TH);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(IDLE_GAP - 1);
    localparam logic [12:0]        c_max_bits = 13'(MAX_BITS);
    localparam logic [12:0]        c_cnt_sat  = 13'h1FFF;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_parse = 2'd1;
    localparam logic [1:0] c_st_stop  = 2'd2;

    logic [c_sr_w-1:0]  r_sr;
    logic [3:0]         r_one;
    logic [3:0]         r_zero;
    logic [1:0]         r_state;
    logic [1:0]         r_rate;
    logic [c_ph_w-1:0]  r_phase;
    logic [c_gap_w-1:0] r_gap;
    logic [12:0]        r_bit_cnt;
    logic               r_bit_en;
    logic               r_bit;
    logic               r_end;
    logic               r_end_col;
    logic               r_end_err;

    logic [c_sum_w-1:0] w_sum [4][4];   // [rate code][window]
    logic [1:0]         w_rate_sel;
    logic [1:0]         w_rate_eff;
    logic [3:0]         w_one;
    logic [3:0]         w_zero;
    logic [c_ph_w-1:0]  w_phase_last;
    logic               w_win_err;
    logic               w_limit_hit;

    function automatic logic [c_sum_w-1:0] f_popcount(input logic [HALF_SAMPLES-1:0] v);
        logic [c_sum_w-1:0] acc;
        acc = '0;
        for (int k = 0; k < HALF_SAMPLES; k++) begin
            acc = acc + c_sum_w'(v[k]);
        end
        return acc;
    endfunction

    // Window sums for every rate code; code 3 is wired as code 0
    for (genvar gr = 0; gr < 4; gr++) begin : g_rate
        localparam int c_h = (gr == 3) ? HALF_SAMPLES : (HALF_SAMPLES >> gr);
        localparam logic [HALF_SAMPLES-1:0] c_mask = {HALF_SAMPLES{1'b1}} >> (HALF_SAMPLES - c_h);
        for (genvar gw = 0; gw < 4; gw++) begin : g_win
            assign w_sum[gr][gw] = f_popcount(r_sr[gw*c_h +: HALF_SAMPLES] & c_mask);
        end
    end

    // The live rate only matters while waiting for SOF; a frame uses its latched rate
    assign w_rate_sel = (r_state == c_st_idle) ? bus.rate : r_rate;
    assign w_rate_eff = (bus.rate == 2'd3) ? 2'd0 : bus.rate;

    for (genvar gc = 0; gc < 4; gc++) begin : g_cls
        assign w_one[gc]  = (w_sum[w_rate_sel][gc] >= c_one_th);
        assign w_zero[gc] = (w_sum[w_rate_sel][gc] <= c_zero_th);
    end

    // A window that is neither clearly present nor clearly absent is an error
    assign w_win_err = |(~(r_one ^ r_zero));

    // Last phase value of one bit period (2H - 1) for the latched rate
    always_comb begin
        case (r_rate)
            2'd1:    w_phase_last = c_ph_w'(HALF_SAMPLES - 1);
            2'd2:    w_phase_last = c_ph_w'(HALF_SAMPLES / 2 - 1);
            default: w_phase_last = c_ph_w'(2 * HALF_SAMPLES - 1);
        endcase
    end

`ifdef NFCA_RX_FRAME_LIMIT_EN
    assign w_limit_hit = (r_bit_cnt >= c_max_bits);
`else
    logic w_unused_max_bits;
    assign w_limit_hit       = 1'b0;
    assign w_unused_max_bits = ^c_max_bits;
`endif

    // Sample history, window flags, frame FSM and one-clock output pulses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sr      <= '0;
            r_one     <= '0;
            r_zero    <= '0;
            r_state   <= c_st_idle;
            r_rate    <= 2'd0;
            r_phase   <= '0;
            r_gap     <= '0;
            r_bit_cnt <= '0;
            r_bit_en  <= 1'b0;
            r_bit     <= 1'b0;
            r_end     <= 1'b0;
            r_end_col <= 1'b0;
            r_end_err <= 1'b0;
        end else begin
            r_bit_en  <= 1'b0;
            r_end     <= 1'b0;
            r_end_col <= 1'b0;
            r_end_err <= 1'b0;
            if (bus.rx_ask_en) begin
                r_sr   <= {r_sr[c_sr_w-2:0], bus.rx_ask};
                r_one  <= w_one;
                r_zero <= w_zero;
                case (r_state)
                    c_st_idle: begin
                        r_gap <= '0;
                        // SOF: subcarrier in W1 only, the other three windows quiet
                        if (r_one == 4'b0010 && r_zero == 4'b1101) begin
                            r_state   <= c_st_parse;
                            r_phase   <= '0;
                            r_bit_cnt <= '0;
                            r_rate    <= w_rate_eff;
                        end
                    end
                    c_st_parse: begin
                        if (r_phase == w_phase_last) begin
                            r_phase <= '0;
                            if (w_win_err || w_limit_hit) begin
                                r_end     <= 1'b1;
                                r_end_err <= 1'b1;
                                r_state   <= c_st_stop;
                            end else if (r_one[1:0] == 2'b00) begin
                                r_end   <= 1'b1;
                                r_state <= c_st_stop;
                            end else if (r_one[1:0] == 2'b11) begin
                                r_end     <= 1'b1;
                                r_end_col <= 1'b1;
                                r_state   <= c_st_stop;
                            end else begin
                                r_bit_en <= 1'b1;
                                r_bit    <= r_one[1];
                                if (r_bit_cnt != c_cnt_sat) begin
                                    r_bit_cnt <= r_bit_cnt + 13'd1;
                                end
                            end
                        end else begin
                            r_phase <= r_phase + c_ph_w'(1);
                        end
                    end
                    c_st_stop: begin
                        if (bus.rx_ask) begin
                            r_gap <= '0;
                        end else if (r_gap == c_gap_last) begin
                            r_gap   <= '0;
                            r_state <= c_st_idle;
                        end else begin
                            r_gap <= r_gap + c_gap_w'(1);
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign bus.rx_bit_en  = r_bit_en;
    assign bus.rx_bit     = r_bit;
    assign bus.rx_end     = r_end;
    assign bus.rx_end_col = r_end_col;
    assign bus.rx_end_err = r_end_err;
    assign bus.rx_bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire
